// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the four-state instruction sequencer: states, opcodes,
// accumulator-source and ALU-select codes, and the decoded strobe bundle.
package cpu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HALT   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_DECODE = 2'b10,
    ST_EXEC   = 2'b11
  } state_t;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_ADD     = 4'b0001;
  localparam logic [3:0] OP_SUB     = 4'b0010;
  localparam logic [3:0] OP_NOR     = 4'b0011;
  localparam logic [3:0] OP_MOV_AR  = 4'b0100;
  localparam logic [3:0] OP_MOV_RA  = 4'b0101;
  localparam logic [3:0] OP_JZ_REG  = 4'b0110;
  localparam logic [3:0] OP_JZ_IMM  = 4'b0111;
  localparam logic [3:0] OP_JC_REG  = 4'b1000;
  localparam logic [3:0] OP_JNZ_IMM = 4'b1001;
  localparam logic [3:0] OP_JC_IMM  = 4'b1010;
  localparam logic [3:0] OP_SHL     = 4'b1011;
  localparam logic [3:0] OP_SHR     = 4'b1100;
  localparam logic [3:0] OP_LDI     = 4'b1101;
  localparam logic [3:0] OP_JNC_IMM = 4'b1110;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b01;
  localparam logic [1:0] ACC_IMM = 2'b10;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SHL  = 4'b0001;
  localparam logic [3:0] ALU_SHR  = 4'b0011;

  typedef struct packed {
    logic [3:0] sel_alu;
    logic [1:0] sel_acc;
    logic       load_acc;
    logic       load_reg;
    logic       load_pc;
    logic       sel_pc;
    logic       inc_pc;
  } strobe_t;

  // Branch condition for the six conditional-jump opcodes.
  function automatic logic branch_taken(input logic [3:0] op, input logic z, input logic c);
    case (op)
      OP_JZ_REG, OP_JZ_IMM: branch_taken = z;
      OP_JC_REG, OP_JC_IMM: branch_taken = c;
      OP_JNZ_IMM:           branch_taken = !z;
      OP_JNC_IMM:           branch_taken = !c;
      default:              branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Purely combinational opcode+flags to strobe decode; the FSM applies the
// result only during EXEC and forces zero otherwise.
module cpu_sequencer_decode
  import cpu_sequencer_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic                z,
  input  logic                c,
  output strobe_t             strobes,
  output logic                halt_op,
  output logic                illegal_op
);

  always_comb begin
    strobes    = '0;
    halt_op    = 1'b0;
    // Any opcode bit above the 4-bit field makes the instruction illegal.
    illegal_op = (op >> 4) != '0;
    case (op[3:0])
      OP_NOP: strobes.inc_pc = 1'b1;
      OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
        strobes.sel_acc  = ACC_ALU;
        strobes.load_acc = 1'b1;
        strobes.inc_pc   = 1'b1;
        case (op[3:0])
          OP_ADD:  strobes.sel_alu = ALU_ADD;
          OP_SUB:  strobes.sel_alu = ALU_SUB;
          OP_NOR:  strobes.sel_alu = ALU_NOR;
          OP_SHL:  strobes.sel_alu = ALU_SHL;
          default: strobes.sel_alu = ALU_SHR;
        endcase
      end
      OP_MOV_AR: begin
        strobes.sel_acc  = ACC_REG;
        strobes.load_acc = 1'b1;
        strobes.inc_pc   = 1'b1;
      end
      OP_MOV_RA: begin
        strobes.load_reg = 1'b1;
        strobes.inc_pc   = 1'b1;
      end
      OP_LDI: begin
        strobes.sel_acc  = ACC_IMM;
        strobes.load_acc = 1'b1;
        strobes.inc_pc   = 1'b1;
      end
      OP_JZ_REG, OP_JZ_IMM, OP_JC_REG, OP_JC_IMM, OP_JNZ_IMM, OP_JNC_IMM: begin
        strobes.load_pc = branch_taken(op[3:0], z, c);
        strobes.inc_pc  = !branch_taken(op[3:0], z, c);
        strobes.sel_pc  = branch_taken(op[3:0], z, c) &&
                          (op[3:0] == OP_JZ_REG || op[3:0] == OP_JC_REG);
      end
      OP_HALT: halt_op = 1'b1;
      default: strobes = '0;
    endcase
    if (illegal_op) begin
      strobes = '0;
      halt_op = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Four-state HALT/FETCH/DECODE/EXEC control sequencer. The opcode and flags are
// captured in DECODE so EXEC strobes ignore any input change during EXEC.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int ALUSEL_W  = 4,
  parameter int RESET_RUN = 1
) (
  input  logic                clk,
  input  logic                CLB,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Z,
  input  logic                C,
  input  logic                mem_ready,
  input  logic                run,
  output logic                LoadIR,
  output logic                IncPC,
  output logic                SelPC,
  output logic                LoadPC,
  output logic                LoadReg,
  output logic                LoadAcc,
  output logic [1:0]          SelAcc,
  output logic [ALUSEL_W-1:0] SelALU,
  output logic [1:0]          state,
  output logic                halted,
  output logic                illegal
);

  localparam state_t RESET_STATE = (RESET_RUN != 0) ? ST_FETCH : ST_HALT;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                z_q, c_q, illegal_q;
  strobe_t             dec_strobes, strobes;
  logic                dec_halt, dec_illegal, load_ir;

  cpu_sequencer_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .op         (op_q),
    .z          (z_q),
    .c          (c_q),
    .strobes    (dec_strobes),
    .halt_op    (dec_halt),
    .illegal_op (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q   <= RESET_STATE;
      op_q      <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        op_q <= Opcode;
        z_q  <= Z;
        c_q  <= C;
      end
      if (state_q == ST_EXEC && dec_illegal) illegal_q <= 1'b1;
    end
  end

  // mem_ready is a valid-only handshake: the sequencer is always ready in FETCH,
  // so LoadIR follows mem_ready in that cycle and the word is taken on that edge.
  always_comb begin
    state_d = state_q;
    strobes = '0;
    load_ir = 1'b0;
    case (state_q)
      ST_HALT:   if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        load_ir = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        strobes = dec_strobes;
        state_d = (dec_halt || dec_illegal) ? ST_HALT : ST_FETCH;
      end
      default:   state_d = ST_HALT;
    endcase
    // Reset suppresses every strobe, even in the middle of an instruction.
    if (CLB) begin
      strobes = '0;
      load_ir = 1'b0;
    end
  end

  assign LoadIR  = load_ir;
  assign IncPC   = strobes.inc_pc;
  assign SelPC   = strobes.sel_pc;
  assign LoadPC  = strobes.load_pc;
  assign LoadReg = strobes.load_reg;
  assign LoadAcc = strobes.load_acc;
  assign SelAcc  = strobes.sel_acc;
  assign SelALU  = ALUSEL_W'(strobes.sel_alu);
  assign state   = state_q;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;

endmodule
